// File: rtl/alu_dispatch.sv
// alu_dispatch: issue/writeback stage wrapped around a registered ALU.
// One instruction in flight; operands come from an internal 8 x DW register file.
module alu_dispatch #(
   parameter int DW      = 32,
   parameter int ALU_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   input  logic [15:0]   instr,
   output logic          instr_ready,
   output logic [31:0]   operate_select,
   output logic [DW-1:0] operate_a,
   output logic [DW-1:0] operate_b,
   input  logic [DW-1:0] alu_result,
   output logic          wb_valid,
   output logic [2:0]    wb_addr,
   output logic [DW-1:0] wb_data,
   output logic          zero,
   output logic          err,
   input  logic [2:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      LOADI,
      ERR
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [2:0]    cnt;
   logic [2:0]    rd_q;
   logic [8:0]    imm_q;
   logic [DW-1:0] rf [8];
   logic [3:0]    op;
   logic          xfer;
   logic          wr_en;
   logic [DW-1:0] imm_ext;
   logic [DW-1:0] wr_data;

   assign op       = instr[15:12];
   assign xfer     = instr_valid && instr_ready && (state == IDLE);
   assign imm_ext  = {{(DW-9){imm_q[8]}}, imm_q};
   assign dbg_data = rf[dbg_addr];
   assign wr_en    = (state == LOADI) ||
                     ((state == WAIT) && (cnt == 3'd1));
   assign wr_data  = (state == LOADI) ? imm_ext : alu_result;

   // Next state: decode the opcode on transfer, single-cycle hops otherwise.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (xfer) begin
               unique case (1'b1)
                  !op[3]:        state_nx = ISSUE;
                  (op == 4'd8):  state_nx = LOADI;
                  default:       state_nx = ERR;
               endcase
            end
         end
         ISSUE:   state_nx = WAIT;
         WAIT:    if (cnt == 3'd1) state_nx = IDLE;
         LOADI:   state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Control, ALU operand drive and writeback status registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         instr_ready    <= 1'b0;
         cnt            <= '0;
         rd_q           <= '0;
         imm_q          <= '0;
         operate_select <= '0;
         operate_a      <= '0;
         operate_b      <= '0;
         wb_valid       <= 1'b0;
         wb_addr        <= '0;
         wb_data        <= '0;
         zero           <= 1'b0;
         err            <= 1'b0;
      end else begin
         state       <= state_nx;
         instr_ready <= (state_nx == IDLE);
         wb_valid    <= wr_en;
         err         <= xfer && (state_nx == ERR);
         if (xfer) begin
            rd_q  <= instr[11:9];
            imm_q <= instr[8:0];
         end
         if (xfer && (state_nx == ISSUE)) begin
            operate_select <= {28'd0, op};
            operate_a      <= rf[instr[8:6]];
            operate_b      <= rf[instr[5:3]];
         end else if ((state_nx != ISSUE) && (state_nx != WAIT)) begin
            operate_select <= '0;
            operate_a      <= '0;
            operate_b      <= '0;
         end
         if (state == ISSUE) begin
            cnt <= 3'(ALU_LAT);
         end else if (state == WAIT) begin
            cnt <= cnt - 3'd1;
         end
         if (wr_en) begin
            wb_addr <= rd_q;
            wb_data <= wr_data;
            zero    <= (wr_data == '0);
         end
      end
   end

   // Register file; entry 0 is never written so it always reads zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            rf[i] <= '0;
         end
      end else if (wr_en && (rd_q != 3'd0)) begin
         rf[rd_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed bench with a transaction model for the
// latency-1 instance and literal checks for a latency-3 instance.
module tb_alu_dispatch;

   localparam int DW = 32;
   localparam int LAT1 = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic [15:0]   instr;
   logic          instr_ready;
   logic [31:0]   operate_select;
   logic [DW-1:0] operate_a;
   logic [DW-1:0] operate_b;
   logic [DW-1:0] alu_result;
   logic          wb_valid;
   logic [2:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic          zero;
   logic          err;
   logic [2:0]    dbg_addr;
   logic [DW-1:0] dbg_data;

   logic          iv3;
   logic [15:0]   in3;
   logic          rdy3;
   logic [31:0]   sel3;
   logic [DW-1:0] a3;
   logic [DW-1:0] b3;
   logic [DW-1:0] res3;
   logic          wbv3;
   logic [2:0]    wba3;
   logic [DW-1:0] wbd3;
   logic          zero3;
   logic          err3;
   logic [2:0]    dbga3;
   logic [DW-1:0] dbgd3;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit dbg_en = 1'b0;
   logic [2:0] dbg_force = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign dbg_addr = dbg_en ? dbg_force : cyc[2:0];

   alu_dispatch #(.DW(DW), .ALU_LAT(LAT1)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready),
      .operate_select(operate_select),
      .operate_a(operate_a), .operate_b(operate_b),
      .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .zero(zero), .err(err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   alu_dispatch #(.DW(DW), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .instr_valid(iv3), .instr(in3),
      .instr_ready(rdy3),
      .operate_select(sel3),
      .operate_a(a3), .operate_b(b3),
      .alu_result(res3),
      .wb_valid(wbv3), .wb_addr(wba3),
      .wb_data(wbd3), .zero(zero3), .err(err3),
      .dbg_addr(dbga3), .dbg_data(dbgd3)
   );

   function automatic logic [31:0] alu_fn(input logic [31:0] s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      case (s[3:0])
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~a;
         4'd6:    return a << 1;
         4'd7:    return a >> 1;
         default: return '0;
      endcase
   endfunction

   function automatic logic [15:0] enc(input int op, input int rd,
                                       input int rs1, input int rs2);
      return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
   endfunction

   function automatic logic [15:0] li(input int rd, input logic [8:0] imm);
      return {4'd8, 3'(rd), imm};
   endfunction

   // Model ALUs: registered pipelines of depth 1 and 3.
   logic [31:0] p3 [3];
   always @(posedge clk) begin
      alu_result <= alu_fn(operate_select, operate_a, operate_b);
      p3[0] <= alu_fn(sel3, a3, b3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign res3 = p3[2];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Transaction model of the latency-1 instance, advanced once per edge.
   logic [31:0] m_r [8];
   logic        m_ready, m_wbv, m_err, m_zero;
   logic [2:0]  m_wba, m_rd;
   logic [31:0] m_wbd, m_sel, m_a, m_b, m_imm;
   bit          busy = 1'b0;
   bit          started = 1'b0;
   int          kind, ecnt, due;

   task automatic step();
      logic [31:0] v;
      m_wbv = 1'b0;
      m_err = 1'b0;
      ecnt++;
      if (!rst) begin
         foreach (m_r[i]) m_r[i] = '0;
         {m_ready, m_zero, busy} = '0;
         {m_sel, m_a, m_b, m_wbd} = '0;
         m_wba = '0;
         return;
      end
      if (busy) begin
         if (ecnt == due) begin
            busy = 1'b0;
            m_ready = 1'b1;
            if (kind != 2) begin
               v = (kind == 0) ? alu_fn(m_sel, m_a, m_b) : m_imm;
               if (m_rd != 0) m_r[m_rd] = v;
               m_wbv = 1'b1;
               m_wba = m_rd;
               m_wbd = v;
               m_zero = (v == 0);
            end
            {m_sel, m_a, m_b} = '0;
         end
      end else if (m_ready && instr_valid) begin
         busy = 1'b1;
         m_ready = 1'b0;
         m_rd = instr[11:9];
         m_imm = 32'($signed(instr[8:0]));
         if (instr[15:12] < 8) begin
            kind = 0;
            due = ecnt + 1 + LAT1;
            m_sel = 32'(instr[15:12]);
            m_a = m_r[instr[8:6]];
            m_b = m_r[instr[5:3]];
         end else begin
            kind = (instr[15:12] == 8) ? 1 : 2;
            due = ecnt + 1;
            m_err = (kind == 2);
         end
      end else begin
         m_ready = 1'b1;
      end
   endtask

   // Compare every cycle against the model, then advance it.
   always @(negedge clk) begin
      if (started) begin
         chk("ready", instr_ready, m_ready);
         chk("wb_valid", wb_valid, m_wbv);
         chk("wb_addr", wb_addr, m_wba);
         chk("wb_data", wb_data, m_wbd);
         chk("zero", zero, m_zero);
         chk("err", err, m_err);
         chk("op_sel", operate_select, m_sel);
         chk("op_a", operate_a, m_a);
         chk("op_b", operate_b, m_b);
         chk("dbg", dbg_data, m_r[dbg_addr]);
      end
      step();
      started = 1'b1;
   end

   task automatic send(input logic [15:0] w, output int t);
      bit ok;
      ok = 1'b0;
      t = 0;
      @(posedge clk); #1;
      instr_valid = 1'b1;
      instr = w;
      for (int j = 0; j < 12 && !ok; j++) begin
         @(negedge clk);
         if (instr_ready) begin
            ok = 1'b1;
            t = cyc + 1;
         end
      end
      chk("accept", 32'(ok), 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic wait_wb(output int w);
      bit ok;
      ok = 1'b0;
      w = 0;
      for (int j = 0; j < 12 && !ok; j++) begin
         @(negedge clk);
         if (wb_valid) begin
            ok = 1'b1;
            w = cyc;
         end
      end
      chk("wb_seen", 32'(ok), 1);
   endtask

   task automatic dbg_chk(input int a, input logic [31:0] exp);
      dbg_force = 3'(a);
      dbg_en = 1'b1;
      #1;
      chk("dbg_lit", dbg_data, exp);
      dbg_en = 1'b0;
   endtask

   task automatic send3(input logic [15:0] w);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      iv3 = 1'b1;
      in3 = w;
      for (int j = 0; j < 12 && !ok; j++) begin
         @(negedge clk);
         ok = rdy3;
      end
      chk("accept3", 32'(ok), 1);
      @(posedge clk); #1;
      iv3 = 1'b0;
   endtask

   initial begin
      int t, w, ne, nw;
      int te [4];
      logic [15:0] w4 [4];
      rst = 1'b0;
      instr_valid = 1'b0;
      instr = '0;
      iv3 = 1'b0;
      in3 = '0;
      dbga3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("ready_in_rst", instr_ready, 0);
      chk("opa_in_rst", operate_a, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", instr_ready, 1);

      send(li(1, 9'd5), t);
      wait_wb(w);
      chk("li_r1", wb_data, 5);
      chk("li_lat", w - t, 1);
      send(li(2, 9'h1FD), t);
      wait_wb(w);
      chk("li_r2", wb_data, 32'hFFFF_FFFD);
      send(enc(0, 3, 1, 2), t);
      wait_wb(w);
      chk("add_addr", wb_addr, 3);
      chk("add_data", wb_data, 2);
      chk("add_zero", zero, 0);
      chk("add_lat", w - t, 2);
      dbg_chk(2, 32'hFFFF_FFFD);
      dbg_chk(3, 2);

      send(enc(1, 4, 1, 1), t);
      wait_wb(w);
      chk("sub_data", wb_data, 0);
      chk("sub_zero", zero, 1);
      send(li(5, 9'd1), t);
      wait_wb(w);
      chk("li_zero_clr", zero, 0);

      w4[0] = enc(0, 4, 1, 2);
      w4[1] = enc(4, 5, 1, 2);
      w4[2] = enc(3, 6, 4, 5);
      w4[3] = enc(6, 7, 1, 0);
      @(posedge clk); #1;
      instr_valid = 1'b1;
      instr = w4[0];
      for (int i = 0; i < 4; i++) begin
         bit ok;
         ok = 1'b0;
         te[i] = 0;
         for (int j = 0; j < 12 && !ok; j++) begin
            @(negedge clk);
            if (instr_ready) begin
               ok = 1'b1;
               te[i] = cyc + 1;
            end
         end
         chk("bp_accept", 32'(ok), 1);
         @(posedge clk); #1;
         if (i < 3) instr = w4[i+1];
         else instr_valid = 1'b0;
      end
      for (int i = 1; i < 4; i++) chk("bp_spacing", te[i] - te[i-1], 3);
      repeat (3) @(negedge clk);
      dbg_chk(5, 32'hFFFF_FFF8);
      dbg_chk(6, 32'hFFFF_FFFA);
      dbg_chk(7, 32'h0000_000A);

      send(16'hA123, t);
      ne = 0;
      nw = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         ne += int'(err);
         nw += int'(wb_valid);
      end
      chk("ill_err_cnt", ne, 1);
      chk("ill_wb_cnt", nw, 0);
      dbg_chk(1, 5);
      send(li(0, 9'd7), t);
      wait_wb(w);
      chk("r0_addr", wb_addr, 0);
      chk("r0_data", wb_data, 7);
      dbg_chk(0, 0);

      send(enc(5, 2, 1, 0), t);
      wait_wb(w);
      chk("not_data", wb_data, 32'hFFFF_FFFA);
      send(enc(2, 3, 6, 1), t);
      wait_wb(w);
      chk("and_zero", zero, 1);
      send(enc(7, 4, 2, 0), t);
      wait_wb(w);
      chk("shr_data", wb_data, 32'h7FFF_FFFD);
      send(enc(0, 1, 1, 1), t);
      wait_wb(w);
      chk("alias_data", wb_data, 10);

      send(enc(0, 3, 1, 2), t);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", instr_ready, 0);
      chk("rst_wbv", wb_valid, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_ready", instr_ready, 1);
      chk("rel_wbv", wb_valid, 0);
      chk("rel_sel", operate_select, 0);
      chk("rel_a", operate_a, 0);
      chk("rel_b", operate_b, 0);
      for (int i = 0; i < 8; i++) dbg_chk(i, 0);

      send3(li(1, 9'd100));
      @(posedge clk); #1;
      chk("l3_li_wbv", wbv3, 1);
      chk("l3_li_data", wbd3, 100);
      send3(li(2, 9'h1FD));
      @(posedge clk); #1;
      send3(enc(0, 3, 1, 2));
      for (int k = 0; k < 4; k++) begin
         chk("l3_sel", sel3, 0);
         chk("l3_a", a3, 100);
         chk("l3_b", b3, 32'hFFFF_FFFD);
         chk("l3_wbv_early", wbv3, 0);
         @(posedge clk); #1;
      end
      chk("l3_wbv", wbv3, 1);
      chk("l3_addr", wba3, 3);
      chk("l3_data", wbd3, 32'h61);
      chk("l3_a_clr", a3, 0);
      chk("l3_ready", rdy3, 1);
      dbga3 = 3'd3;
      #1;
      chk("l3_dbg", dbgd3, 32'h61);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
